// File: rtl/mapper_banked_rom.sv
// mapper_banked_rom: parametrised banked-ROM mapper for MSX cartridge slots.
// Translates Z80 addresses in the bank window to flat ROM/SDRAM addresses.
// Segment registers are written either by memory writes into the window or
// by an I/O-port write with 16K-mirror and 32K modes.
// Optional feature macro: MAPPER_BANKED_READBACK_EN (I/O-port readback of io_reg).
module mapper_banked_rom #(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned BANK_AW   = 13,
    parameter int unsigned SEG_W     = 8,
    parameter int unsigned ADDR_W    = 27,
    parameter logic [15:0] WIN_BASE  = 16'h4000,
    parameter logic [7:0]  IO_PORT   = 8'h77
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sel,
    input  logic              io_mode,
    input  logic              mreq,
    input  logic              iorq,
    input  logic              wr,
    input  logic              rd,
    input  logic [15:0]       addr,
    input  logic [7:0]        data,
    output logic              ram_cs,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rd_oe,
    output logic [7:0]        rd_data
);

    localparam int unsigned IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [SEG_W-1:0] bank_reg [NUM_BANKS];
    logic [7:0]       io_reg;
    logic             wr_q;

    logic [16:0]      off;
    logic [16:0]      bank_full;
    logic             in_window;
    logic [IDX_W-1:0] n;
    logic [1:0]       n2;
    logic [SEG_W-1:0] seg_mem;
    logic [SEG_W-1:0] seg;
    logic             strobe;
    logic             mem_we;
    logic             io_we;

    // 17-bit offset so addresses below the window go negative instead of wrapping
    assign off       = {1'b0, addr} - {1'b0, WIN_BASE};
    assign bank_full = off >> BANK_AW;
    assign in_window = ~off[16] & (bank_full < 17'(NUM_BANKS));
    assign n         = bank_full[IDX_W-1:0];
    assign n2        = bank_full[1:0];

    assign ram_cs    = sel & mreq & in_window;

    // Edge-detected write strobe: one update per CPU write regardless of wr length
    assign strobe = sel & wr & ~wr_q & (mreq ^ iorq);
    assign mem_we = strobe & ~io_mode & mreq & in_window;
    assign io_we  = strobe & io_mode & iorq & (addr[7:0] == IO_PORT);

    // Segment select: stored bank register in memory mode, io_reg-derived in I/O mode
    always_comb begin
        seg_mem = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (n == IDX_W'(i)) seg_mem = bank_reg[i];
        end
        if (!io_mode) begin
            seg = seg_mem;
        end else if (io_reg[7:6] == 2'b11) begin
            seg = SEG_W'({io_reg[5:1], n2});
        end else begin
            seg = SEG_W'({io_reg[5:0], n2[0]});
        end
    end

    // Address translation, all ones outside the window
    always_comb begin
        if (ram_cs) rom_addr = ADDR_W'({seg, addr[BANK_AW-1:0]});
        else        rom_addr = '1;
    end

    // Previous-cycle wr for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wr_q <= 1'b0;
        else          wr_q <= wr;
    end

    // Bank and I/O register updates; banks reset to the identity mapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) bank_reg[i] <= SEG_W'(i);
            io_reg <= 8'h00;
        end else begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                if (mem_we && (n == IDX_W'(i))) bank_reg[i] <= SEG_W'(data);
            end
            if (io_we) io_reg <= data;
        end
    end

`ifdef MAPPER_BANKED_READBACK_EN
    logic rd_q;
    logic rd_start;

    assign rd_start = io_mode & iorq & rd & ~rd_q & (addr[7:0] == IO_PORT);

    // Readback: capture io_reg on IN rising edge, drop enable the cycle after rd falls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q    <= 1'b0;
            rd_oe   <= 1'b0;
            rd_data <= 8'hFF;
        end else begin
            rd_q <= rd;
            if (rd_start) begin
                rd_oe   <= 1'b1;
                rd_data <= io_reg;
            end else if (!rd) begin
                rd_oe   <= 1'b0;
            end
        end
    end
`else
    logic unused_rd;

    assign unused_rd = &{1'b0, rd};
    assign rd_oe     = 1'b0;
    assign rd_data   = 8'hFF;
`endif

endmodule

// File: tb/tb_mapper_banked_rom.sv
// tb_mapper_banked_rom: directed, table-driven bench for mapper_banked_rom.
// Build with MAPPER_BANKED_READBACK_EN defined to exercise readback.
module tb_mapper_banked_rom;

    logic        clk;
    logic        reset_n;
    logic        sel;
    logic        io_mode;
    logic        mreq;
    logic        iorq;
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        ram_cs;
    logic [26:0] rom_addr;
    logic        rd_oe;
    logic [7:0]  rd_data;

    int checks = 0;
    int errors = 0;

    localparam logic [26:0] ONES = 27'h7FF_FFFF;

    mapper_banked_rom #(
        .NUM_BANKS(4),
        .BANK_AW(13),
        .SEG_W(8),
        .ADDR_W(27),
        .WIN_BASE(16'h4000),
        .IO_PORT(8'h77)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sel(sel),
        .io_mode(io_mode),
        .mreq(mreq),
        .iorq(iorq),
        .wr(wr),
        .rd(rd),
        .addr(addr),
        .data(data),
        .ram_cs(ram_cs),
        .rom_addr(rom_addr),
        .rd_oe(rd_oe),
        .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          phase;
        string       name;
        logic        sel;
        logic        io_mode;
        logic [15:0] addr;
        logic        exp_cs;
        logic [26:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input int p, input string nm, input logic s, input logic m,
                       input logic [15:0] a, input logic cs, input logic [26:0] ra);
        vec_t v;
        v.phase = p; v.name = nm; v.sel = s; v.io_mode = m;
        v.addr = a; v.exp_cs = cs; v.exp_addr = ra;
        vecs.push_back(v);
    endtask

    // Apply every read vector tagged with phase p
    task automatic run_phase(input int p);
        foreach (vecs[i]) begin
            if (vecs[i].phase == p) begin
                @(negedge clk);
                sel = vecs[i].sel; io_mode = vecs[i].io_mode;
                mreq = 1'b1; rd = 1'b1; addr = vecs[i].addr;
                #1;
                chk({vecs[i].name, ".cs"}, 32'(ram_cs), 32'(vecs[i].exp_cs));
                chk({vecs[i].name, ".addr"}, 32'(rom_addr), 32'(vecs[i].exp_addr));
            end
        end
        @(negedge clk);
        mreq = 1'b0; rd = 1'b0; sel = 1'b1;
    endtask

    // CPU write held for 'hold' clock edges; data changes after the first edge
    task automatic bus_write(input logic s, input logic m, input logic i,
                             input logic [15:0] a, input logic [7:0] d, input int hold);
        @(negedge clk);
        sel = s; mreq = m; iorq = i; addr = a; data = d; wr = 1'b1;
        for (int k = 1; k < hold; k++) begin
            @(negedge clk);
            data = d ^ 8'h33;
        end
        @(negedge clk);
        wr = 1'b0; mreq = 1'b0; iorq = 1'b0; data = 8'h00; sel = 1'b1;
    endtask

    initial begin
        // phase 1: defaults, memory mode
        add(1, "m_6123", 1, 0, 16'h6123, 1, 27'h0_2123);
        add(1, "m_4000", 1, 0, 16'h4000, 1, 27'h0_0000);
        add(1, "m_8000", 1, 0, 16'h8000, 1, 27'h0_4000);
        add(1, "m_bfff", 1, 0, 16'hBFFF, 1, 27'h0_7FFF);
        add(1, "m_3fff", 1, 0, 16'h3FFF, 0, ONES);
        add(1, "m_c000", 1, 0, 16'hC000, 0, ONES);
        add(1, "m_nosel", 0, 0, 16'h6000, 0, ONES);
        // phase 2: after 2A written to bank 2 and ignored writes
        add(2, "p2_4000", 1, 0, 16'h4000, 1, 27'h0_0000);
        add(2, "p2_6000", 1, 0, 16'h6000, 1, 27'h0_2000);
        add(2, "p2_8000", 1, 0, 16'h8000, 1, 27'h5_4000);
        add(2, "p2_a000", 1, 0, 16'hA000, 1, 27'h0_6000);
        add(2, "p2_io0_6000", 1, 1, 16'h6000, 1, 27'h0_2000);
        // phase 3: io_reg = C5 (32K)
        add(3, "c5_a000", 1, 1, 16'hA000, 1, 27'h1_6000);
        add(3, "c5_4000", 1, 1, 16'h4000, 1, 27'h1_0000);
        add(3, "c5_6000", 1, 1, 16'h6000, 1, 27'h1_2000);
        // phase 4: io_reg = 05 (16K mirrored)
        add(4, "05_4000", 1, 1, 16'h4000, 1, 27'h1_4000);
        add(4, "05_8000", 1, 1, 16'h8000, 1, 27'h1_4000);
        add(4, "05_6000", 1, 1, 16'h6000, 1, 27'h1_6000);
        add(4, "05_a000", 1, 1, 16'hA000, 1, 27'h1_6000);
        add(4, "05_c000", 1, 1, 16'hC000, 0, ONES);
        // phase 5: back to memory mode, stored banks intact
        add(5, "p5_4000", 1, 0, 16'h4000, 1, 27'h0_0000);
        add(5, "p5_8000", 1, 0, 16'h8000, 1, 27'h5_4000);

        reset_n = 1'b0; sel = 1'b0; io_mode = 1'b0; mreq = 1'b0; iorq = 1'b0;
        wr = 1'b0; rd = 1'b0; addr = 16'h0000; data = 8'h00;
        #12;
        chk("rst.rd_oe", 32'(rd_oe), 32'd0);
        chk("rst.rd_data", 32'(rd_data), 32'hFF);
        chk("rst.rom_addr", 32'(rom_addr), 32'(ONES));
        @(negedge clk);
        reset_n = 1'b1; sel = 1'b1;

        run_phase(1);

        // Held memory write: old mapping before the edge, new after, one update only
        @(negedge clk);
        sel = 1'b1; io_mode = 1'b0; mreq = 1'b1; addr = 16'h8000; data = 8'h2A; wr = 1'b1;
        #1;
        chk("wr.same_cycle_old", 32'(rom_addr), 32'h0_4000);
        @(posedge clk); #1;
        chk("wr.next_cycle_new", 32'(rom_addr), 32'h5_4000);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            data = 8'h2A ^ 8'h33;
        end
        @(negedge clk);
        wr = 1'b0; data = 8'h00; addr = 16'h8001; rd = 1'b1;
        #1;
        chk("wr.read_8001", 32'(rom_addr), 32'h5_4001);
        rd = 1'b0; mreq = 1'b0;

        // Writes that must be ignored
        bus_write(1, 1, 0, 16'h3FFF, 8'h55, 1);
        bus_write(1, 1, 0, 16'hC000, 8'h55, 1);
        bus_write(0, 1, 0, 16'h4000, 8'h55, 1);
        bus_write(1, 1, 1, 16'h6077, 8'h55, 1);
        bus_write(1, 0, 1, 16'h0077, 8'hFF, 1);
        run_phase(2);

        // I/O mode: memory write ignored, OUT 77h = C5, wrong port ignored
        @(negedge clk); io_mode = 1'b1;
        bus_write(1, 1, 0, 16'h4000, 8'h99, 1);
        bus_write(1, 0, 1, 16'h0077, 8'hC5, 1);
        bus_write(1, 0, 1, 16'h0076, 8'h00, 1);
        run_phase(3);

        bus_write(1, 0, 1, 16'h0077, 8'h05, 3);
        run_phase(4);

`ifdef MAPPER_BANKED_READBACK_EN
        @(negedge clk);
        io_mode = 1'b1; iorq = 1'b1; rd = 1'b1; addr = 16'h0077;
        #1;
        chk("rb.before_edge", 32'(rd_oe), 32'd0);
        @(posedge clk); #1;
        chk("rb.oe", 32'(rd_oe), 32'd1);
        chk("rb.data", 32'(rd_data), 32'h05);
        @(posedge clk); #1;
        chk("rb.oe_held", 32'(rd_oe), 32'd1);
        @(negedge clk);
        iorq = 1'b0; rd = 1'b0;
        @(posedge clk); #1;
        chk("rb.oe_clear", 32'(rd_oe), 32'd0);
`else
        @(negedge clk);
        io_mode = 1'b1; iorq = 1'b1; rd = 1'b1; addr = 16'h0077;
        @(posedge clk); #1;
        chk("rb_off.oe", 32'(rd_oe), 32'd0);
        chk("rb_off.data", 32'(rd_data), 32'hFF);
        @(negedge clk);
        iorq = 1'b0; rd = 1'b0;
`endif

        @(negedge clk); io_mode = 1'b0;
        run_phase(5);

        // Reset during a held write: immediate clear, then one strobe after release
        @(negedge clk);
        sel = 1'b1; io_mode = 1'b0; mreq = 1'b1; addr = 16'h8000; data = 8'h77; wr = 1'b1;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("rstw.cleared", 32'(rom_addr), 32'h0_4000);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rstw.one_strobe", 32'(rom_addr), 32'hE_E000);
        @(negedge clk);
        wr = 1'b0; mreq = 1'b0;
        io_mode = 1'b1; mreq = 1'b1; addr = 16'h6000;
        #1;
        chk("rstw.io_reg_zero", 32'(rom_addr), 32'h0_2000);
        mreq = 1'b0;
`ifdef MAPPER_BANKED_READBACK_EN
        @(negedge clk);
        iorq = 1'b1; rd = 1'b1; addr = 16'h0077;
        @(posedge clk); #1;
        chk("rstw.rb_oe", 32'(rd_oe), 32'd1);
        chk("rstw.rb_data", 32'(rd_data), 32'h00);
        @(negedge clk);
        iorq = 1'b0; rd = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
